button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//  Front end for the raw panel buttons (up/down/mode/adjust), feeding state_machine and led_interface.
//  Per button: synchronises the raw input, debounces it, and emits one-cycle press and release pulses.
//  Also emits a one-cycle long-press pulse and auto-repeat press pulses while a repeat-enabled button is held.
//  Runs on the 10 kHz display/control clock.
// PARAMETERS
//  N_BTN            4     number of buttons; bit0=up, bit1=down, bit2=mode, bit3=adjust
//  SYNC_STAGES      2     synchroniser flops per button (>=2)
//  DEBOUNCE_CYCLES  200   consecutive differing samples needed to accept a level change (20 ms @10 kHz)
//  LONG_CYCLES      8000  held cycles, counted from the press pulse, until the long pulse (0.8 s)
//  REPEAT_CYCLES    2000  auto-repeat period after a long press (0.2 s)
//  REPEAT_MASK      4'b0011  per-button auto-repeat enable (up and down only)
// PORTS
//  clk          in   1      control clock (10 kHz in system)
//  rst_n        in   1      asynchronous active-low reset
//  btn_raw      in   N_BTN  raw, asynchronous, active-high button inputs
//  btn_level    out  N_BTN  debounced button level
//  btn_press    out  N_BTN  1-cycle pulse on accepted press and on each auto-repeat
//  btn_release  out  N_BTN  1-cycle pulse on accepted release
//  btn_long     out  N_BTN  1-cycle pulse when held LONG_CYCLES
// BEHAVIOUR
//  - Reset: asynchronous. Clears all sync flops, counters and FSMs; all outputs are 0. No pulses during reset.
//  - Buttons are fully independent; simultaneous activity on any bits is handled per bit with no priority.
//  - Sync: a SYNC_STAGES-deep flop chain per bit; sync = last stage.
//  - Debounce: per-bit count db_cnt, width $clog2(DEBOUNCE_CYCLES+1).
//    - If sync == btn_level, db_cnt <= 0.
//    - Otherwise db_cnt increments. When db_cnt == DEBOUNCE_CYCLES-1 and sync still differs:
//      btn_level <= sync, db_cnt <= 0.
//    - Any agreeing sample restarts the count, so glitches shorter than DEBOUNCE_CYCLES are ignored.
//  - Latency: a clean raw edge reaches btn_level SYNC_STAGES+DEBOUNCE_CYCLES rising edges later.
//  - Per-bit FSM: IDLE, HELD, REPEAT. Hold counter hcnt, width $clog2(max(LONG,REPEAT)+1).
//    - IDLE: on the edge where btn_level goes 0->1, btn_press=1 in the first cycle btn_level=1.
//      Go to HELD with hcnt=1.
//    - HELD: hcnt increments each cycle. When hcnt == LONG_CYCLES, btn_long=1 that cycle.
//      - If REPEAT_MASK[i]=1, also btn_press=1 that cycle; go to REPEAT with hcnt=1.
//      - If REPEAT_MASK[i]=0, hcnt saturates at LONG_CYCLES and the FSM stays in HELD; no further pulses.
//    - REPEAT: hcnt increments. At hcnt == REPEAT_CYCLES, btn_press=1 and hcnt <= 1; repeats indefinitely.
//    - From HELD or REPEAT, on the edge where btn_level goes 1->0: btn_release=1 in the first cycle
//      btn_level=0; go to IDLE with hcnt=0. Release takes priority over any long/repeat pulse due that cycle.
//  - All outputs are registered. Each pulse is exactly one cycle.
//    A press and a release of the same bit never assert in the same cycle.
//  - Reset mid-hold: the level drops to 0 immediately and no release pulse is emitted.
//    After reset, a still-held button is re-detected as a new press after the normal latency.
// TESTING (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
//  1. btn_raw=4'hF through reset; release rst_n at edge 0 -> all outputs 0 until edge 6;
//     btn_level=4'hF at edge 6 and btn_press=4'hF for that one cycle only.
//  2. bit2 raw high for 3 cycles, then low -> btn_level, btn_press, btn_release stay 0 throughout.
//  3. bit2 raw high for 12 cycles, then low -> single btn_press[2] at raw-rise+6;
//     single btn_release[2] at raw-fall+6; btn_long[2] never asserts.
//  4. bit0 held 50 cycles, press pulse at cycle t -> btn_long[0] at t+20 with btn_press[0];
//     further btn_press[0] at t+25, t+30, t+35...; btn_release[0] at raw-fall+6.
//  5. bit3 held 50 cycles -> one btn_press[3] at t, one btn_long[3] at t+20, no repeat pulses;
//     bits 0 and 1 toggled concurrently respond independently.
//  6. rst_n pulsed low at t+23 during the bit0 hold -> outputs 0 asynchronously; no release pulse;
//     after rst_n rises, a new btn_press[0] appears 6 cycles later.

Source files
------------

// File: rtl/button_if.sv
// Purpose : bundles the raw button inputs with the conditioned level and pulse outputs.
// Latency : none, this is wiring only.
// Backpress: none; every signal is sampled on each clock and nothing can be stalled.
// Ports   : btn_raw (to conditioner), btn_level / btn_press / btn_release / btn_long (from conditioner).
interface button_if #(
   parameter int N_BTN = 4
);
   logic [N_BTN-1:0] btn_raw;      // raw asynchronous active-high buttons
   logic [N_BTN-1:0] btn_level;    // debounced level
   logic [N_BTN-1:0] btn_press;    // 1-cycle pulse: accepted press or auto-repeat
   logic [N_BTN-1:0] btn_release;  // 1-cycle pulse: accepted release
   logic [N_BTN-1:0] btn_long;     // 1-cycle pulse: held long enough

   // Drives the raw buttons and consumes the conditioned outputs.
   modport master (
      output btn_raw,
      input  btn_level, btn_press, btn_release, btn_long
   );

   // The conditioner itself.
   modport slave (
      input  btn_raw,
      output btn_level, btn_press, btn_release, btn_long
   );
endinterface

// File: rtl/button_conditioner.sv
// Purpose : per-button sync, debounce, press/release/long pulses and auto-repeat.
// Latency : a clean raw edge reaches btn_level and its pulse SYNC_STAGES+DEBOUNCE_CYCLES edges later.
// Backpress: none; the buttons are free-running inputs and the pulses are not held for a consumer.
// Ports   : clk, rst_n (async, active low), bus (button_if.slave: btn_raw in, level/pulses out).
module button_conditioner #(
   parameter int               N_BTN           = 4,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = 200,
   parameter int               LONG_CYCLES     = 8000,
   parameter int               REPEAT_CYCLES   = 2000,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0011
) (
   input  logic     clk,
   input  logic     rst_n,
   button_if.slave  bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HC_W = $clog2(HMAX + 1);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HC_W-1:0] HC_LONG = HC_W'(LONG_CYCLES);
   localparam logic [HC_W-1:0] HC_REP  = HC_W'(REPEAT_CYCLES);
   localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HELD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q, sync_d;
   logic [N_BTN-1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic [N_BTN-1:0][HC_W-1:0]        hcnt_q, hcnt_d;
   logic [N_BTN-1:0][1:0]             state_q, state_d;
   logic [N_BTN-1:0]                  level_q, level_d;
   logic [N_BTN-1:0]                  long_done_q, long_done_d;
   logic [N_BTN-1:0]                  press_q, press_d;
   logic [N_BTN-1:0]                  release_q, release_d;
   logic [N_BTN-1:0]                  long_q, long_d;
   logic [N_BTN-1:0]                  sync;

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
      db_cnt_d    = db_cnt_q;
      level_d     = level_q;
      hcnt_d      = hcnt_q;
      state_d     = state_q;
      long_done_d = long_done_q;
      press_d     = '0;
      release_d   = '0;
      long_d      = '0;

      for (int i = 0; i < N_BTN; i++) begin
         // Debounce: only an unbroken run of differing samples moves the level.
         if (sync[i] == level_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            level_d[i]  = sync[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end

         // The FSM looks at level_d so each pulse lines up with the level edge
         // in the registered outputs. level_q is always 0 while IDLE.
         case (state_q[i])
            ST_IDLE: begin
               if (level_d[i]) begin
                  press_d[i]     = 1'b1;
                  state_d[i]     = ST_HELD;
                  hcnt_d[i]      = HC_ONE;
                  long_done_d[i] = 1'b0;
               end
            end
            ST_HELD: begin
               if (!level_d[i]) begin
                  // Release wins over any long/repeat pulse due this cycle.
                  release_d[i]   = 1'b1;
                  state_d[i]     = ST_IDLE;
                  hcnt_d[i]      = '0;
                  long_done_d[i] = 1'b0;
               end else if (long_done_q[i]) begin
                  // Non-repeating button past its long press: counter parked at LONG.
                  hcnt_d[i] = hcnt_q[i];
               end else if (hcnt_q[i] == HC_LONG) begin
                  long_d[i] = 1'b1;
                  if (REPEAT_MASK[i]) begin
                     press_d[i] = 1'b1;
                     state_d[i] = ST_REPEAT;
                     hcnt_d[i]  = HC_ONE;
                  end else begin
                     long_done_d[i] = 1'b1;
                  end
               end else begin
                  hcnt_d[i] = hcnt_q[i] + 1'b1;
               end
            end
            ST_REPEAT: begin
               if (!level_d[i]) begin
                  release_d[i] = 1'b1;
                  state_d[i]   = ST_IDLE;
                  hcnt_d[i]    = '0;
               end else if (hcnt_q[i] == HC_REP) begin
                  press_d[i] = 1'b1;
                  hcnt_d[i]  = HC_ONE;
               end else begin
                  hcnt_d[i] = hcnt_q[i] + 1'b1;
               end
            end
            default: begin
               state_d[i]     = ST_IDLE;
               hcnt_d[i]      = '0;
               long_done_d[i] = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         db_cnt_q    <= '0;
         level_q     <= '0;
         hcnt_q      <= '0;
         state_q     <= '0;
         long_done_q <= '0;
         press_q     <= '0;
         release_q   <= '0;
         long_q      <= '0;
      end else begin
         sync_q      <= sync_d;
         db_cnt_q    <= db_cnt_d;
         level_q     <= level_d;
         hcnt_q      <= hcnt_d;
         state_q     <= state_d;
         long_done_q <= long_done_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
      end
   end

   assign bus.btn_level   = level_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = release_q;
   assign bus.btn_long    = long_q;

endmodule
